instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage of the 16-bit processor. Holds the program counter and fetches one instruction word from instruction memory per request over a req/ack handshake. It latches the instruction register and advances the PC. Its `ir_out`/`pc_out` feed the jump-address combiner (IR[11:0] with PC[15:12]), and it accepts the resulting jump target, plus branch and register targets, back as next-PC sources.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value after reset
- PC_STEP, 2, sequential PC increment per fetched word
- MAX_WAIT, 8, maximum REQ cycles without `imem_ack` before timeout (1..255)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- fetch_en  in  1  control unit requests one instruction fetch
- pc_load  in  1  load PC from source chosen by `pc_sel`
- pc_sel  in  2  00 hold, 01 branch_target, 10 jump_target, 11 reg_target
- branch_target  in  16  branch destination
- jump_target  in  16  jump destination from IR/PC combiner
- reg_target  in  16  register-indirect destination
- imem_addr  out  16  instruction memory address (= PC register)
- imem_req  out  1  memory read request
- imem_data  in  16  instruction word, valid with `imem_ack`
- imem_ack  in  1  memory completes read this cycle
- ir_out  out  16  latched instruction register
- pc_out  out  16  current PC register
- ir_valid  out  1  one-cycle pulse: new instruction in `ir_out`
- busy  out  1  high in REQ and DONE
- fetch_err  out  1  sticky timeout flag

## Operation
- State machine IDLE / REQ / DONE.
- IDLE:
  - `fetch_en`=1 → REQ.
  - `pc_load`=1 → PC <= selected source; `pc_sel`=00 leaves PC unchanged.
  - Both asserted in the same cycle: load and transition happen at one edge, so the fetch uses the newly loaded PC.
- REQ:
  - `imem_req`=1, `imem_addr`=PC, wait counter increments every cycle.
  - `imem_ack`=1 sampled → IR <= `imem_data`, PC <= PC + PC_STEP (16-bit, wraps mod 2^16), → DONE.
  - Counter reaches MAX_WAIT without ack → `fetch_err`=1, PC and IR unchanged, → IDLE.
- DONE: `ir_valid`=1 for exactly one cycle, → IDLE.
- `pc_load` and `fetch_en` outside IDLE are ignored, never queued.
- `imem_ack` outside REQ is ignored.
- `fetch_err` clears on the next accepted `fetch_en`.
- The wait counter clears on entry to REQ.
- `imem_data` is sampled only on an acked REQ cycle.

## Timing
- Reset values: PC=RESET_PC, ir_out=0, ir_valid=0, imem_req=0, busy=0, fetch_err=0, state IDLE, counter 0. They apply asynchronously on `reset` assertion.
- Reset during REQ aborts the fetch; no `ir_valid` pulse, PC returns to RESET_PC.
- Fetch latency:
  - `fetch_en` high at edge N → `imem_req` high from cycle N+1.
  - Ack sampled at edge N+1+k (k wait cycles, k < MAX_WAIT) → `ir_valid` high during cycle N+2+k.
  - Minimum fetch_en-to-ir_valid latency is 2 cycles.
- `ir_out` and `pc_out` update at the same edge and are stable while `ir_valid`=1 and until the next ack or pc_load.
- `imem_req` deasserts the cycle after ack or timeout.
- `imem_addr` is constant for the whole REQ period.
- Timeout: with no ack, `fetch_err` rises at the edge ending the MAX_WAIT-th REQ cycle, and `busy` falls at that same edge.
- Outputs are registered, except `imem_addr`/`pc_out` (direct PC register) and `busy`/`imem_req` (decoded from state register).

## Test plan
- Reset with RESET_PC=16'h0000, then `fetch_en` pulse, memory acks on the first REQ cycle with 16'h2ABC → `imem_addr`=0000, `ir_valid` pulse 2 cycles after `fetch_en`, `ir_out`=2ABC, `pc_out`=0002.
- Memory inserts 3 wait cycles before ack with 16'h1234 → `imem_req` high 4 cycles, `imem_addr` constant, `ir_valid` 5 cycles after `fetch_en`, PC advances by 2 exactly once.
- No ack, MAX_WAIT=8 → `fetch_err`=1 after 8 REQ cycles, PC and IR unchanged. Next `fetch_en` clears `fetch_err`.
- In IDLE with PC=16'h5000, assert `pc_load` (pc_sel=10, jump_target=16'h5123) together with `fetch_en` → fetch address 5123; after ack `pc_out`=5125. Assert `pc_load` during REQ → ignored.
- PC=16'hFFFE, fetch with ack → `pc_out`=16'h0000 (wrap); `pc_sel`=00 load → PC unchanged.
- Assert `reset` mid-REQ, then ack the next cycle → no `ir_valid`, `imem_req`=0 immediately, PC=RESET_PC, `ir_out`=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, fetches one instruction word per request over a
// req/ack handshake, latches IR and advances the PC; accepts next-PC targets.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 2,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        pc_load,
  input  logic [1:0]  pc_sel,
  input  logic [15:0] branch_target,
  input  logic [15:0] jump_target,
  input  logic [15:0] reg_target,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_data,
  input  logic        imem_ack,
  output logic [15:0] ir_out,
  output logic [15:0] pc_out,
  output logic        ir_valid,
  output logic        busy,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetchState_t;

  localparam logic [7:0]  LAST_WAIT = 8'(MAX_WAIT - 1);
  localparam logic [15:0] STEP      = 16'(PC_STEP);

  fetchState_t state, nextState;

  logic [15:0] pcReg, pcNext;
  logic [15:0] irReg;
  logic [15:0] loadTarget;
  logic        irValidReg;
  logic        errReg;
  logic [7:0]  waitCnt;

  logic accept;
  logic ackHit;
  logic timeoutHit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    accept     = 1'b0;
    ackHit     = 1'b0;
    timeoutHit = 1'b0;
    unique case (state)
      IDLE: begin
        if (fetch_en) begin
          accept    = 1'b1;
          nextState = REQ;
        end
      end
      REQ: begin
        // Ack wins over timeout on the MAX_WAIT-th cycle.
        if (imem_ack) begin
          ackHit    = 1'b1;
          nextState = DONE;
        end else if (waitCnt == LAST_WAIT) begin
          timeoutHit = 1'b1;
          nextState  = IDLE;
        end
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    loadTarget = pcReg;
    unique case (pc_sel)
      2'b00: loadTarget = pcReg;
      2'b01: loadTarget = branch_target;
      2'b10: loadTarget = jump_target;
      2'b11: loadTarget = reg_target;
      default: loadTarget = pcReg;
    endcase
  end

  // A load in IDLE lands at the same edge as fetch acceptance, so the fetch
  // that follows addresses the freshly loaded PC.
  always_comb begin
    pcNext = pcReg;
    if (state == IDLE && pc_load) begin
      pcNext = loadTarget;
    end else if (ackHit) begin
      pcNext = pcReg + STEP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcReg      <= RESET_PC;
      irReg      <= '0;
      irValidReg <= 1'b0;
      errReg     <= 1'b0;
      waitCnt    <= '0;
    end else begin
      pcReg      <= pcNext;
      irValidReg <= ackHit;
      if (ackHit) begin
        irReg <= imem_data;
      end
      if (timeoutHit) begin
        errReg <= 1'b1;
      end else if (accept) begin
        errReg <= 1'b0;
      end
      if (accept || ackHit || timeoutHit) begin
        waitCnt <= '0;
      end else if (state == REQ) begin
        waitCnt <= waitCnt + 8'd1;
      end
    end
  end

  assign imem_addr = pcReg;
  assign pc_out    = pcReg;
  assign ir_out    = irReg;
  assign ir_valid  = irValidReg;
  assign fetch_err = errReg;
  assign imem_req  = (state == REQ);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized sequence checked against a transaction-level PC/IR model.
module tb_instruction_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int unsigned PC_STEP  = 2;
  localparam int unsigned MAX_WAIT = 8;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        pc_load;
  logic [1:0]  pc_sel;
  logic [15:0] branch_target;
  logic [15:0] jump_target;
  logic [15:0] reg_target;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_data;
  logic        imem_ack;
  logic [15:0] ir_out;
  logic [15:0] pc_out;
  logic        ir_valid;
  logic        busy;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC, IR and sticky error flag.
  logic [15:0] mPc;
  logic [15:0] mIr;
  logic        mErr;

  instruction_fetch_unit #(
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_en     (fetch_en),
    .pc_load      (pc_load),
    .pc_sel       (pc_sel),
    .branch_target(branch_target),
    .jump_target  (jump_target),
    .reg_target   (reg_target),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_data    (imem_data),
    .imem_ack     (imem_ack),
    .ir_out       (ir_out),
    .pc_out       (pc_out),
    .ir_valid     (ir_valid),
    .busy         (busy),
    .fetch_err    (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pickTarget(input logic [1:0] sel, input logic [15:0] cur,
                                             input logic [15:0] bt, input logic [15:0] jt,
                                             input logic [15:0] rt);
    case (sel)
      2'b01:   return bt;
      2'b10:   return jt;
      2'b11:   return rt;
      default: return cur;
    endcase
  endfunction

  // One fetch transaction: optional PC load in the accept cycle, `waits` idle
  // REQ cycles then an ack (or no ack at all), with ignored noise on pc_load,
  // fetch_en and imem_ack whenever the unit is not in IDLE.
  task automatic runFetch(input string name, input logic [15:0] data, input int unsigned waits,
                          input bit ackOn, input bit doLoad, input logic [1:0] sel,
                          input logic [15:0] bt, input logic [15:0] jt, input logic [15:0] rt);
    bit          timeout;
    int unsigned reqCycles;
    logic [15:0] addr;
    @(negedge clk);
    fetch_en      = 1'b1;
    pc_load       = doLoad;
    pc_sel        = sel;
    branch_target = bt;
    jump_target   = jt;
    reg_target    = rt;
    if (doLoad) mPc = pickTarget(sel, mPc, bt, jt, rt);
    addr      = mPc;
    mErr      = 1'b0;
    timeout   = !ackOn || (waits >= MAX_WAIT);
    reqCycles = timeout ? MAX_WAIT : waits + 1;
    for (int unsigned c = 0; c < reqCycles; c++) begin
      @(negedge clk);
      fetch_en      = 1'($urandom_range(0, 1));
      pc_load       = 1'($urandom_range(0, 1));
      pc_sel        = 2'($urandom);
      branch_target = 16'($urandom);
      jump_target   = 16'($urandom);
      reg_target    = 16'($urandom);
      checks++;
      if ({imem_req, busy, ir_valid, fetch_err} !== 4'b1100) begin
        errors++;
        $display("FAIL %s req-cycle %0d: req/busy/valid/err=%b required 1100", name, c,
                 {imem_req, busy, ir_valid, fetch_err});
      end
      checks++;
      if (imem_addr !== addr || pc_out !== addr) begin
        errors++;
        $display("FAIL %s addr cycle %0d: imem_addr=%h pc_out=%h required %h", name, c,
                 imem_addr, pc_out, addr);
      end
      if (!timeout && c == reqCycles - 1) begin
        imem_ack  = 1'b1;
        imem_data = data;
      end else begin
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
      end
    end
    @(negedge clk);
    fetch_en = 1'b0;
    pc_load  = 1'b0;
    imem_ack = 1'b0;
    if (timeout) begin
      mErr = 1'b1;
      checks++;
      if ({imem_req, busy, ir_valid, fetch_err} !== 4'b0001 || pc_out !== mPc || ir_out !== mIr) begin
        errors++;
        $display("FAIL %s timeout: req/busy/valid/err=%b pc=%h ir=%h required 0001 pc=%h ir=%h",
                 name, {imem_req, busy, ir_valid, fetch_err}, pc_out, ir_out, mPc, mIr);
      end
      if (ackOn) begin
        imem_ack  = 1'b1;
        imem_data = 16'($urandom);
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || imem_req !== 1'b0 || ir_out !== mIr || pc_out !== mPc) begin
          errors++;
          $display("FAIL %s late-ack: valid=%b req=%b ir=%h pc=%h required 0 0 %h %h",
                   name, ir_valid, imem_req, ir_out, pc_out, mIr, mPc);
        end
      end
    end else begin
      mIr = data;
      mPc = mPc + 16'(PC_STEP);
      checks++;
      if ({imem_req, busy, ir_valid, fetch_err} !== 4'b0110 || ir_out !== mIr || pc_out !== mPc) begin
        errors++;
        $display("FAIL %s done: req/busy/valid/err=%b ir=%h pc=%h required 0110 ir=%h pc=%h",
                 name, {imem_req, busy, ir_valid, fetch_err}, ir_out, pc_out, mIr, mPc);
      end
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = 16'($urandom);
      @(negedge clk);
      imem_ack = 1'b0;
      checks++;
      if ({imem_req, busy, ir_valid} !== 3'b000 || ir_out !== mIr || pc_out !== mPc) begin
        errors++;
        $display("FAIL %s after-done: req/busy/valid=%b ir=%h pc=%h required 000 ir=%h pc=%h",
                 name, {imem_req, busy, ir_valid}, ir_out, pc_out, mIr, mPc);
      end
    end
  endtask

  task automatic loadPc(input string name, input logic [1:0] sel, input logic [15:0] bt,
                        input logic [15:0] jt, input logic [15:0] rt);
    @(negedge clk);
    pc_load       = 1'b1;
    pc_sel        = sel;
    branch_target = bt;
    jump_target   = jt;
    reg_target    = rt;
    mPc = pickTarget(sel, mPc, bt, jt, rt);
    @(negedge clk);
    pc_load = 1'b0;
    checks++;
    if (pc_out !== mPc || busy !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s: pc_out=%h busy=%b req=%b required pc=%h busy=0 req=0",
               name, pc_out, busy, imem_req, mPc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    mPc  = RESET_PC;
    mIr  = '0;
    mErr = 1'b0;
    checks++;
    if ({imem_req, busy, ir_valid, fetch_err} !== 4'b0000 || pc_out !== RESET_PC || ir_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset: req/busy/valid/err=%b pc=%h ir=%h required 0000 pc=%h ir=0000",
               {imem_req, busy, ir_valid, fetch_err}, pc_out, ir_out, RESET_PC);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_fetch;
    runFetch("basic", 16'h2ABC, 0, 1'b1, 1'b0, 2'b00, '0, '0, '0);
  endtask

  task automatic test_wait_states;
    runFetch("wait3", 16'h1234, 3, 1'b1, 1'b0, 2'b00, '0, '0, '0);
    runFetch("wait-max", 16'hBEEF, MAX_WAIT - 1, 1'b1, 1'b0, 2'b00, '0, '0, '0);
  endtask

  task automatic test_timeout;
    runFetch("timeout", 16'hDEAD, 0, 1'b0, 1'b0, 2'b00, '0, '0, '0);
    runFetch("err-clear", 16'h0F0F, 1, 1'b1, 1'b0, 2'b00, '0, '0, '0);
  endtask

  task automatic test_load_with_fetch;
    loadPc("load-branch", 2'b01, 16'h5000, 16'h1111, 16'h2222);
    runFetch("load+fetch", 16'h7777, 2, 1'b1, 1'b1, 2'b10, 16'h3333, 16'h5123, 16'h4444);
  endtask

  task automatic test_wrap;
    loadPc("load-reg", 2'b11, 16'h1111, 16'h2222, 16'hFFFE);
    runFetch("wrap", 16'hA5A5, 1, 1'b1, 1'b0, 2'b00, '0, '0, '0);
    loadPc("load-hold", 2'b00, 16'h1234, 16'h5678, 16'h9ABC);
  endtask

  task automatic test_reset_mid_req;
    @(negedge clk);
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    mPc  = RESET_PC;
    mIr  = '0;
    mErr = 1'b0;
    checks++;
    if ({imem_req, busy, ir_valid, fetch_err} !== 4'b0000 || pc_out !== RESET_PC || ir_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset-mid-req: req/busy/valid/err=%b pc=%h ir=%h required 0000 pc=%h ir=0000",
               {imem_req, busy, ir_valid, fetch_err}, pc_out, ir_out, RESET_PC);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    imem_ack  = 1'b1;
    imem_data = 16'hCAFE;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      checks++;
      if (ir_valid !== 1'b0 || imem_req !== 1'b0 || ir_out !== mIr || pc_out !== mPc) begin
        errors++;
        $display("FAIL reset-ack cycle %0d: valid=%b req=%b ir=%h pc=%h required 0 0 %h %h",
                 i, ir_valid, imem_req, ir_out, pc_out, mIr, mPc);
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        loadPc("rand-load", 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      end else begin
        runFetch("rand-fetch", 16'($urandom), $urandom_range(0, MAX_WAIT + 1),
                 ($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)), 2'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom));
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    fetch_en      = 1'b0;
    pc_load       = 1'b0;
    pc_sel        = 2'b00;
    branch_target = '0;
    jump_target   = '0;
    reg_target    = '0;
    imem_data     = '0;
    imem_ack      = 1'b0;
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_timeout();
    test_load_with_fetch();
    test_wrap();
    test_reset_mid_req();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
